// File: rtl/snake_board_pkg.sv
// Shared definitions for the snake board rasteriser.
// - Default board geometry and the per-frame segment limit.
// - The controller state encoding.
// - Row-word and coordinate types.
package snake_board_pkg;

  localparam int GRID_DEF    = 28;
  localparam int CW_DEF      = 5;
  localparam int MAX_SEG_DEF = 16;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_DRAW,
    ST_WAIT
  } state_t;

  typedef logic [GRID_DEF-1:0] row_t;
  typedef logic [CW_DEF-1:0]   coord_t;

endpackage

// File: rtl/snake_board_bank.sv
// One GRID x GRID occupancy bitmap.
// Word index = row (x), bit index = column (y).
// Ports:
//   clk, rst          clock and synchronous active-high reset (zeroes all rows)
//   clr_en, clr_row   zero one whole row at the next edge
//   set_en, set_x/y   set a single bit at the next edge (caller guarantees range)
//   rd_x, rd_y        combinational lookup address
//   rd_bit            stored bit, 0 when the address is off the board
module snake_board_bank
  import snake_board_pkg::*;
#(
  parameter int GRID = GRID_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic [CW-1:0] clr_row,
  input  logic          set_en,
  input  logic [CW-1:0] set_x,
  input  logic [CW-1:0] set_y,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic          rd_bit
);

  logic [GRID-1:0] mem [GRID];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GRID; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        mem[clr_row] <= '0;
      end
      if (set_en) begin
        mem[set_x][set_y] <= 1'b1;
      end
    end
  end

  // One extra bit on the compare so GRID == 2^CW still works.
  assign rd_bit = (({1'b0, rd_x} < (CW+1)'(GRID)) && ({1'b0, rd_y} < (CW+1)'(GRID)))
                  ? mem[rd_x][rd_y] : 1'b0;

endmodule

// File: rtl/snake_board_raster.sv
// Double-buffered occupancy rasteriser for the snake board.
// The back bank is cleared row by row, segment beats are drawn into it,
// and it becomes the front bank at the next frame_start seen in WAIT.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   frame_start                 frame boundary pulse (only honoured in WAIT)
//   seg_valid/seg_ready         segment stream handshake
//   seg_x, seg_y, seg_last      segment coordinate and end-of-frame marker
//   rd_x, rd_y, rd_bit          registered front-bank lookup (1-cycle latency)
//   front_bank                  bank currently displayed
//   busy                        high while clearing or drawing
//   swap_done                   pulse in the cycle front_bank shows its new value
//   oob_err, overflow           sticky error flags
module snake_board_raster
  import snake_board_pkg::*;
#(
  parameter int GRID    = GRID_DEF,
  parameter int CW      = CW_DEF,
  parameter int MAX_SEG = MAX_SEG_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          seg_valid,
  output logic          seg_ready,
  input  logic [CW-1:0] seg_x,
  input  logic [CW-1:0] seg_y,
  input  logic          seg_last,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output logic          rd_bit,
  output logic          front_bank,
  output logic          busy,
  output logic          swap_done,
  output logic          oob_err,
  output logic          overflow
);

  localparam int SCW = $clog2(MAX_SEG + 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  row_cnt;
  logic [SCW-1:0] seg_cnt;
  logic           accept;
  logic           room;
  logic           seg_in_rng;
  logic           set_en;
  logic           clr_en;
  logic           rd_b0, rd_b1;

  function automatic logic coord_ok(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return ({1'b0, x} < (CW+1)'(GRID)) && ({1'b0, y} < (CW+1)'(GRID));
  endfunction

  assign room       = (seg_cnt < SCW'(MAX_SEG));
  assign seg_in_rng = coord_ok(seg_x, seg_y);
  assign set_en     = accept & room & seg_in_rng;

  always_comb begin
    state_nxt = state;
    seg_ready = 1'b0;
    busy      = 1'b0;
    clr_en    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        if (row_cnt == CW'(GRID - 1)) state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        busy      = 1'b1;
        seg_ready = 1'b1;
        accept    = seg_valid;
        if (seg_valid && seg_last) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt    <= '0;
      seg_cnt    <= '0;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
      oob_err    <= 1'b0;
      overflow   <= 1'b0;
      rd_bit     <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      // Mux uses the current front_bank, so a read on the swap edge sees the old bank.
      rd_bit    <= front_bank ? rd_b1 : rd_b0;
      if (state == ST_CLEAR) begin
        row_cnt <= (row_cnt == CW'(GRID - 1)) ? '0 : row_cnt + 1'b1;
      end
      if (accept) begin
        if (room) begin
          seg_cnt <= seg_cnt + 1'b1;
          if (!seg_in_rng) oob_err <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
        if (seg_last) seg_cnt <= '0;
      end
      if (state == ST_WAIT && frame_start) begin
        front_bank <= ~front_bank;
        swap_done  <= 1'b1;
      end
    end
  end

  // Writes (clear and set) always target the back bank, ~front_bank.
  snake_board_bank #(.GRID(GRID), .CW(CW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .clr_en  (clr_en & front_bank),
    .clr_row (row_cnt),
    .set_en  (set_en & front_bank),
    .set_x   (seg_x),
    .set_y   (seg_y),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_bit  (rd_b0)
  );

  snake_board_bank #(.GRID(GRID), .CW(CW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .clr_en  (clr_en & ~front_bank),
    .clr_row (row_cnt),
    .set_en  (set_en & ~front_bank),
    .set_x   (seg_x),
    .set_y   (seg_y),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_bit  (rd_b1)
  );

endmodule

// File: tb/tb_snake_board_raster.sv
module tb_snake_board_raster;

  localparam int GRID = 28;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          seg_valid;
  logic          seg_ready;
  logic [CW-1:0] seg_x, seg_y;
  logic          seg_last;
  logic [CW-1:0] rd_x, rd_y;
  logic          rd_bit;
  logic          front_bank;
  logic          busy;
  logic          swap_done;
  logic          oob_err;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   ph;
    int   x;
    int   y;
    logic exp;
  } rvec_t;

  rvec_t tbl[$];

  always #5 clk = ~clk;

  snake_board_raster dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .seg_x       (seg_x),
    .seg_y       (seg_y),
    .seg_last    (seg_last),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_bit      (rd_bit),
    .front_bank  (front_bank),
    .busy        (busy),
    .swap_done   (swap_done),
    .oob_err     (oob_err),
    .overflow    (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (seg_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (seg_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int x, input int y, input logic last);
    seg_x     = CW'(x);
    seg_y     = CW'(y);
    seg_last  = last;
    seg_valid = 1'b1;
    wait_ready();
    step();
    seg_valid = 1'b0;
    seg_last  = 1'b0;
  endtask

  task automatic rd(input int x, input int y, input logic exp, input string name);
    rd_x = CW'(x);
    rd_y = CW'(y);
    step();
    chk(name, rd_bit, exp);
  endtask

  task automatic scan(output int ones);
    ones = 0;
    for (int x = 0; x < GRID; x++) begin
      for (int y = 0; y < GRID; y++) begin
        rd_x = CW'(x);
        rd_y = CW'(y);
        step();
        if (rd_bit === 1'b1) ones++;
        else if (rd_bit !== 1'b0) ones += 1000;
      end
    end
  endtask

  task automatic swap(input logic exp_front);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("swap_front", front_bank, exp_front);
    chk("swap_pulse", swap_done, 1);
    step();
    chk("swap_pulse_end", swap_done, 0);
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ph == p)
        rd(tbl[i].x, tbl[i].y, tbl[i].exp,
           $sformatf("rd_p%0d_%0d_%0d", p, tbl[i].x, tbl[i].y));
    end
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    chk({name, "_busy"}, busy, 1);
    while (seg_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({name, "_cycles"}, n, 28);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    tbl.push_back('{2, 12, 10, 1'b1});
    tbl.push_back('{2, 12, 11, 1'b0});
    tbl.push_back('{2, 10, 10, 1'b1});
    tbl.push_back('{2, 19, 10, 1'b1});
    tbl.push_back('{2,  9, 10, 1'b0});
    tbl.push_back('{2, 20, 10, 1'b0});
    tbl.push_back('{2, 30, 10, 1'b0});
    tbl.push_back('{3,  5,  5, 1'b1});
    tbl.push_back('{3, 28,  3, 1'b0});
    tbl.push_back('{3, 12, 10, 1'b0});
    tbl.push_back('{4,  0,  0, 1'b1});
    tbl.push_back('{4,  0, 15, 1'b1});
    tbl.push_back('{4,  0, 16, 1'b0});
    tbl.push_back('{4,  0, 19, 1'b0});
    tbl.push_back('{4, 12, 10, 1'b0});
    tbl.push_back('{5,  3,  4, 1'b1});
    tbl.push_back('{5,  7,  7, 1'b1});
    tbl.push_back('{5,  0,  0, 1'b0});

    rst = 1'b1; frame_start = 1'b0; seg_last = 1'b0;
    seg_valid = 1'b1; seg_x = CW'(10); seg_y = CW'(10);
    rd_x = '0; rd_y = '0;
    repeat (3) step();
    chk("rst_front", front_bank, 0);
    chk("rst_rd_bit", rd_bit, 0);
    chk("rst_swap", swap_done, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ready", seg_ready, 0);

    // Test 1: 28-cycle clear with seg_valid held high.
    rst = 1'b0;
    count_clear("clear1");

    // Test 2: ten beats x=10..19, y=10; the first is already presented.
    for (int i = 10; i < 20; i++) send(i, 10, i == 19);
    chk("wait_busy", busy, 0);
    chk("wait_ready", seg_ready, 0);
    scan(ones);
    chk("front_blank_before_swap", ones, 0);
    swap(1'b1);
    run_phase(2);

    // Test 3: out-of-range beat then (5,5,last).
    wait_ready();
    send(28, 3, 1'b0);
    chk("oob_set", oob_err, 1);
    send(5, 5, 1'b1);
    swap(1'b0);
    chk("oob_sticky", oob_err, 1);
    run_phase(3);
    scan(ones);
    chk("f3_ones", ones, 1);

    // Test 4: 20 beats on row 0, only first 16 drawn.
    wait_ready();
    for (int i = 0; i < 20; i++) begin
      send(0, i, i == 19);
      if (i == 15) chk("ovf_at_16", overflow, 0);
      if (i == 16) chk("ovf_at_17", overflow, 1);
    end
    swap(1'b1);
    chk("ovf_sticky", overflow, 1);
    run_phase(4);
    scan(ones);
    chk("f4_ones", ones, 16);

    // Test 5: frame_start in CLEAR, DRAW and on the last beat is ignored.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_clear_front", front_bank, 1);
    chk("fs_clear_swap", swap_done, 0);
    chk("fs_clear_busy", busy, 1);
    step();
    chk("fs_clear_swap2", swap_done, 0);
    wait_ready();
    send(3, 4, 1'b0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_draw_front", front_bank, 1);
    chk("fs_draw_swap", swap_done, 0);
    chk("fs_draw_ready", seg_ready, 1);
    seg_x = CW'(7); seg_y = CW'(7); seg_last = 1'b1; seg_valid = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0; seg_valid = 1'b0; seg_last = 1'b0;
    chk("fs_last_front", front_bank, 1);
    chk("fs_last_swap", swap_done, 0);
    chk("fs_last_wait", busy, 0);
    repeat (3) step();
    chk("fs_not_remembered", front_bank, 1);
    swap(1'b0);
    run_phase(5);

    // Test 6: reset mid-DRAW while bank 1 is displayed.
    wait_ready();
    send(2, 2, 1'b1);
    swap(1'b1);
    wait_ready();
    send(1, 1, 1'b0);
    rd(2, 2, 1'b1, "pre_rst_rd");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_front", front_bank, 0);
    chk("rst2_rd_bit", rd_bit, 0);
    chk("rst2_swap", swap_done, 0);
    chk("rst2_oob", oob_err, 0);
    chk("rst2_ovf", overflow, 0);
    chk("rst2_ready", seg_ready, 0);
    count_clear("clear2");
    scan(ones);
    chk("rst2_ones", ones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
